// File: rtl/ft_lockstep_ctrl.sv
// Lockstep controller: compares redundant core write/retire lanes, keeps a checkpoint register file,
// and on an uncorrectable mismatch restores the cores and replays from the last agreed PC.
//
// state   | meaning
// RUN     | lanes compared each cycle, agreed writes/retires committed
// RESTORE | checkpoint register file streamed to the cores, fetch blocked
// REPLAY  | one-cycle replay request with the checkpoint PC
// FATAL   | retries exhausted, held until reset
module ft_lockstep_ctrl #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int PC_WIDTH      = 32,
    parameter int NUM_LANES     = 2,
    parameter int MAX_RETRY     = 3,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_LANES-1:0]            we_i,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_i,
    input  logic [NUM_LANES-1:0]            retire_i,
    input  logic [NUM_LANES*PC_WIDTH-1:0]   pc_i,
    output logic                            restore_valid_o,
    input  logic                            restore_ready_i,
    output logic [ADDR_WIDTH-1:0]           restore_addr_o,
    output logic [DATA_WIDTH-1:0]           restore_data_o,
    output logic                            replay_valid_o,
    output logic [PC_WIDTH-1:0]             replay_addr_o,
    output logic                            fetch_block_o,
    output logic                            corrected_o,
    output logic                            fatal_o,
    output logic [ERR_CNT_WIDTH-1:0]        err_cnt_o
);
    localparam int DEPTH       = 2**ADDR_WIDTH;
    localparam int RETRY_WIDTH = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {S_RUN, S_RESTORE, S_REPLAY, S_FATAL} state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    rf_q [DEPTH];
    logic [PC_WIDTH-1:0]      ckpt_q, ckpt_d;
    logic [RETRY_WIDTH-1:0]   retry_q, retry_d;
    logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic                     corr_q, corr_d;
    logic                     rf_we;

    logic m01, m02, m12;
    logic agree, sel1, correction;
    logic                  v_we, v_ret;
    logic [ADDR_WIDTH-1:0] v_addr;
    logic [DATA_WIDTH-1:0] v_data;
    logic [PC_WIDTH-1:0]   v_pc;

    function automatic logic pair_match(
        input logic we_a, input logic we_b, input logic ret_a, input logic ret_b,
        input logic [ADDR_WIDTH-1:0] addr_a, input logic [ADDR_WIDTH-1:0] addr_b,
        input logic [DATA_WIDTH-1:0] data_a, input logic [DATA_WIDTH-1:0] data_b,
        input logic [PC_WIDTH-1:0] pc_a, input logic [PC_WIDTH-1:0] pc_b);
        return (we_a == we_b) && (ret_a == ret_b)
            && (!we_a || ((addr_a == addr_b) && (data_a == data_b)))
            && (!ret_a || (pc_a == pc_b));
    endfunction

    assign m01 = pair_match(we_i[0], we_i[1], retire_i[0], retire_i[1],
                            addr_i[0 +: ADDR_WIDTH], addr_i[ADDR_WIDTH +: ADDR_WIDTH],
                            data_i[0 +: DATA_WIDTH], data_i[DATA_WIDTH +: DATA_WIDTH],
                            pc_i[0 +: PC_WIDTH], pc_i[PC_WIDTH +: PC_WIDTH]);

    if (NUM_LANES == 3) begin : g_tmr
        assign m02 = pair_match(we_i[0], we_i[2], retire_i[0], retire_i[2],
                                addr_i[0 +: ADDR_WIDTH], addr_i[2*ADDR_WIDTH +: ADDR_WIDTH],
                                data_i[0 +: DATA_WIDTH], data_i[2*DATA_WIDTH +: DATA_WIDTH],
                                pc_i[0 +: PC_WIDTH], pc_i[2*PC_WIDTH +: PC_WIDTH]);
        assign m12 = pair_match(we_i[1], we_i[2], retire_i[1], retire_i[2],
                                addr_i[ADDR_WIDTH +: ADDR_WIDTH], addr_i[2*ADDR_WIDTH +: ADDR_WIDTH],
                                data_i[DATA_WIDTH +: DATA_WIDTH], data_i[2*DATA_WIDTH +: DATA_WIDTH],
                                pc_i[PC_WIDTH +: PC_WIDTH], pc_i[2*PC_WIDTH +: PC_WIDTH]);
        assign agree      = m01 | m02 | m12;
        // lane 1 wins only when lane 0 is the odd one out
        assign sel1       = !m01 && !m02 && m12;
        assign correction = agree && !(m01 && m02 && m12);
    end else begin : g_dmr
        assign m02        = 1'b0;
        assign m12        = 1'b0;
        assign agree      = m01;
        assign sel1       = 1'b0;
        assign correction = 1'b0;
    end

    assign v_we   = sel1 ? we_i[1]     : we_i[0];
    assign v_ret  = sel1 ? retire_i[1] : retire_i[0];
    assign v_addr = sel1 ? addr_i[ADDR_WIDTH +: ADDR_WIDTH] : addr_i[0 +: ADDR_WIDTH];
    assign v_data = sel1 ? data_i[DATA_WIDTH +: DATA_WIDTH] : data_i[0 +: DATA_WIDTH];
    assign v_pc   = sel1 ? pc_i[PC_WIDTH +: PC_WIDTH]       : pc_i[0 +: PC_WIDTH];

    always_comb begin
        state_d = state_q;
        ckpt_d  = ckpt_q;
        retry_d = retry_q;
        idx_d   = idx_q;
        err_d   = err_q;
        corr_d  = 1'b0;
        rf_we   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (agree) begin
                    rf_we  = v_we;
                    corr_d = correction;
                    if (v_ret) begin
                        ckpt_d  = v_pc;
                        retry_d = '0;
                    end
                end else begin
                    err_d = (err_q == '1) ? err_q : err_q + ERR_CNT_WIDTH'(1);
                    if (retry_q == RETRY_WIDTH'(MAX_RETRY)) begin
                        state_d = S_FATAL;
                    end else begin
                        retry_d = retry_q + RETRY_WIDTH'(1);
                        idx_d   = '0;
                        state_d = S_RESTORE;
                    end
                end
            end
            S_RESTORE: begin
                if (restore_ready_i) begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                    if (idx_q == '1) state_d = S_REPLAY;
                end
            end
            S_REPLAY: state_d = S_RUN;
            S_FATAL:  state_d = S_FATAL;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RUN;
            ckpt_q  <= '0;
            retry_q <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            corr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ckpt_q  <= ckpt_d;
            retry_q <= retry_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            corr_q  <= corr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[v_addr] <= v_data;
        end
    end

    assign restore_valid_o = (state_q == S_RESTORE);
    assign restore_addr_o  = (state_q == S_RESTORE) ? idx_q : '0;
    assign restore_data_o  = (state_q == S_RESTORE) ? rf_q[idx_q] : '0;
    assign replay_valid_o  = (state_q == S_REPLAY);
    assign replay_addr_o   = (state_q == S_REPLAY) ? ckpt_q : '0;
    assign fetch_block_o   = (state_q != S_RUN);
    assign fatal_o         = (state_q == S_FATAL);
    assign corrected_o     = corr_q;
    assign err_cnt_o       = err_q;
endmodule

// File: tb/tb_ft_lockstep_ctrl.sv
// Bench for ft_lockstep_ctrl: a dual-lane and a triple-lane instance share one stimulus stream
// and are each checked every cycle against a behavioural model, plus directed scenario checks.
module tb_ft_lockstep_ctrl;
    localparam int AW = 5, DW = 32, PW = 32, EW = 16, MAXR = 3;
    localparam int DEPTH = 2**AW;
    localparam int M_RUN = 0, M_RESTORE = 1, M_REPLAY = 2, M_FATAL = 3;

    logic clk_i = 1'b0, rst_ni = 1'b0, ready = 1'b1;
    always #5 clk_i = ~clk_i;

    logic          lw [3];
    logic          lr [3];
    logic [AW-1:0] la [3];
    logic [DW-1:0] ld [3];
    logic [PW-1:0] lp [3];
    logic [2:0]    we3, ret3;
    logic [3*AW-1:0] addr3;
    logic [3*DW-1:0] data3;
    logic [3*PW-1:0] pc3;
    assign we3   = {lw[2], lw[1], lw[0]};
    assign ret3  = {lr[2], lr[1], lr[0]};
    assign addr3 = {la[2], la[1], la[0]};
    assign data3 = {ld[2], ld[1], ld[0]};
    assign pc3   = {lp[2], lp[1], lp[0]};

    logic r2_rv, r2_pv, r2_fb, r2_co, r2_fa, r3_rv, r3_pv, r3_fb, r3_co, r3_fa;
    logic [AW-1:0] r2_ra, r3_ra;
    logic [DW-1:0] r2_rd, r3_rd;
    logic [PW-1:0] r2_pa, r3_pa;
    logic [EW-1:0] r2_ec, r3_ec;

    ft_lockstep_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_WIDTH(PW), .NUM_LANES(2),
                       .MAX_RETRY(MAXR), .ERR_CNT_WIDTH(EW)) u_dual (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we3[1:0]), .addr_i(addr3[2*AW-1:0]),
        .data_i(data3[2*DW-1:0]), .retire_i(ret3[1:0]), .pc_i(pc3[2*PW-1:0]),
        .restore_valid_o(r2_rv), .restore_ready_i(ready), .restore_addr_o(r2_ra),
        .restore_data_o(r2_rd), .replay_valid_o(r2_pv), .replay_addr_o(r2_pa),
        .fetch_block_o(r2_fb), .corrected_o(r2_co), .fatal_o(r2_fa), .err_cnt_o(r2_ec));

    ft_lockstep_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_WIDTH(PW), .NUM_LANES(3),
                       .MAX_RETRY(MAXR), .ERR_CNT_WIDTH(EW)) u_tmr (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we3), .addr_i(addr3),
        .data_i(data3), .retire_i(ret3), .pc_i(pc3),
        .restore_valid_o(r3_rv), .restore_ready_i(ready), .restore_addr_o(r3_ra),
        .restore_data_o(r3_rd), .replay_valid_o(r3_pv), .replay_addr_o(r3_pa),
        .fetch_block_o(r3_fb), .corrected_o(r3_co), .fatal_o(r3_fa), .err_cnt_o(r3_ec));

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // model state, index 0 = dual-lane instance, 1 = triple-lane instance
    logic [DW-1:0] mrf [2][DEPTH];
    logic [PW-1:0] mckpt [2];
    int mst[2], midx[2], mretry[2], merr[2];
    bit mcorr[2];

    function automatic bit same(input int i, input int j);
        return lw[i] == lw[j] && lr[i] == lr[j]
            && (!lw[i] || (la[i] == la[j] && ld[i] == ld[j]))
            && (!lr[i] || lp[i] == lp[j]);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < DEPTH; a++) mrf[m][a] = '0;
            mckpt[m] = '0; mst[m] = M_RUN; midx[m] = 0; mretry[m] = 0; merr[m] = 0; mcorr[m] = 0;
        end
    endtask

    task automatic model_step(input int m);
        int w;
        bit all3;
        mcorr[m] = 0;
        if (mst[m] == M_RUN) begin
            w = -1;
            if (same(0, 1)) w = 0;
            else if (m == 1 && same(0, 2)) w = 0;
            else if (m == 1 && same(1, 2)) w = 1;
            if (w >= 0) begin
                if (lw[w]) mrf[m][la[w]] = ld[w];
                if (lr[w]) begin mckpt[m] = lp[w]; mretry[m] = 0; end
                all3 = same(0, 1) && same(0, 2) && same(1, 2);
                mcorr[m] = (m == 1) && !all3;
            end else begin
                if (merr[m] < (1 << EW) - 1) merr[m]++;
                if (mretry[m] == MAXR) mst[m] = M_FATAL;
                else begin mretry[m]++; midx[m] = 0; mst[m] = M_RESTORE; end
            end
        end else if (mst[m] == M_RESTORE) begin
            if (ready) begin
                if (midx[m] == DEPTH - 1) mst[m] = M_REPLAY;
                midx[m] = (midx[m] + 1) % DEPTH;
            end
        end else if (mst[m] == M_REPLAY) begin
            mst[m] = M_RUN;
        end
    endtask

    task automatic compare_inst(input int m, input string nm, input logic rv, input logic [AW-1:0] ra,
                                input logic [DW-1:0] rd, input logic pv, input logic [PW-1:0] pa,
                                input logic fb, input logic co, input logic fa, input logic [EW-1:0] ec);
        bit rs = (mst[m] == M_RESTORE);
        bit rp = (mst[m] == M_REPLAY);
        check({nm, "_restore_valid"}, rv, rs);
        check({nm, "_restore_addr"}, ra, rs ? midx[m] : 0);
        check({nm, "_restore_data"}, rd, rs ? mrf[m][midx[m]] : 0);
        check({nm, "_replay_valid"}, pv, rp);
        check({nm, "_replay_addr"}, pa, rp ? mckpt[m] : 0);
        check({nm, "_fetch_block"}, fb, mst[m] != M_RUN);
        check({nm, "_corrected"}, co, mcorr[m]);
        check({nm, "_fatal"}, fa, mst[m] == M_FATAL);
        check({nm, "_err_cnt"}, ec, merr[m]);
    endtask

    task automatic compare_all();
        compare_inst(0, "dual", r2_rv, r2_ra, r2_rd, r2_pv, r2_pa, r2_fb, r2_co, r2_fa, r2_ec);
        compare_inst(1, "tmr", r3_rv, r3_ra, r3_rd, r3_pv, r3_pa, r3_fb, r3_co, r3_fa, r3_ec);
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step(0);
        model_step(1);
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic set_all(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic r, input logic [PW-1:0] p);
        for (int i = 0; i < 3; i++) begin lw[i] = w; la[i] = a; ld[i] = d; lr[i] = r; lp[i] = p; end
    endtask

    task automatic idle();
        set_all(1'b0, '0, '0, 1'b0, '0);
    endtask

    // three mutually disagreeing lanes: uncorrectable for both instances
    task automatic all_differ();
        set_all(1'b1, 5'd1, 32'h1111, 1'b0, '0);
        lw[0] = 1'b0;
        la[2] = 5'd2;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle();
        model_reset();
        #1 compare_all();
        #2 rst_ni = 1'b1;
    endtask

    // Walks the dual instance from RESTORE back to RUN; edges counts the mismatch edge too.
    task automatic run_recovery(input bit bp, output int edges, output int beats, output int replays,
                                output logic [DW-1:0] d3, output logic [PW-1:0] rpc);
        logic [AW-1:0] prev_addr;
        logic prev_ready;
        int k;
        edges = 1; beats = 0; replays = 0; d3 = 'x; rpc = 'x; k = 0;
        prev_ready = 1'b1; prev_addr = '0;
        while (r2_fb && edges < 300) begin
            ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            #1;
            if (bp && !prev_ready && r2_rv) check("bp_hold_addr", r2_ra, prev_addr);
            if (r2_rv && ready) begin
                beats++;
                if (r2_ra == 3) d3 = r2_rd;
            end
            if (r2_pv) begin replays++; rpc = r2_pa; end
            prev_ready = ready; prev_addr = r2_ra;
            cycle();
            edges++; k++;
        end
        ready = 1'b1;
        check("recover_done", r2_fb, 1'b0);
    endtask

    int edges, beats, replays, c;
    logic [DW-1:0] d3;
    logic [PW-1:0] rpc;

    initial begin
        idle();
        model_reset();
        do_reset();
        cycle();

        // clean write then dual mismatch (single-lane outvote for TMR)
        set_all(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 32'h100);
        cycle();
        idle();
        cycle();
        check("clean_fetch_block", r2_fb, 1'b0);
        check("clean_err_cnt", r2_ec, 0);
        set_all(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0);
        ld[1] = 32'hDEADBEEE;
        cycle();
        idle();
        check("mm_fetch_block", r2_fb, 1'b1);
        check("tmr_corrected", r3_co, 1'b1);
        check("tmr_no_block", r3_fb, 1'b0);
        run_recovery(1'b0, edges, beats, replays, d3, rpc);
        check("mm_latency", edges, 1 + DEPTH + 1);
        check("mm_beats", beats, DEPTH);
        check("mm_rf3", d3, 32'hDEADBEEF);
        check("mm_replays", replays, 1);
        check("mm_replay_pc", rpc, 32'h100);
        check("mm_err_cnt", r2_ec, 1);

        // TMR single bad lane on addr 5, then all lanes differ with backpressure
        set_all(1'b1, 5'd5, 32'hA5A5_0005, 1'b0, '0);
        ld[2] = 32'h0BAD_0005;
        cycle();
        idle();
        check("tmr5_corrected", r3_co, 1'b1);
        cycle();
        check("tmr5_pulse_once", r3_co, 1'b0);
        all_differ();
        cycle();
        idle();
        check("tmr_diff_block", r3_fb, 1'b1);
        run_recovery(1'b1, edges, beats, replays, d3, rpc);
        check("bp_beats", beats, DEPTH);
        check("bp_replays", replays, 1);

        // retry exhaustion
        do_reset();
        for (int k = 0; k < 4; k++) begin
            all_differ();
            cycle();
            idle();
            if (k < 3) run_recovery(1'b0, edges, beats, replays, d3, rpc);
        end
        check("exh_fatal", r2_fa, 1'b1);
        check("exh_fatal_tmr", r3_fa, 1'b1);
        check("exh_err_cnt", r2_ec, 4);
        for (int k = 0; k < 5; k++) cycle();
        check("exh_fatal_held", r2_fa & r2_fb, 1'b1);

        // agreed retire between mismatches clears the retry count
        do_reset();
        for (int k = 0; k < 3; k++) begin
            all_differ();
            cycle();
            idle();
            run_recovery(1'b0, edges, beats, replays, d3, rpc);
        end
        set_all(1'b0, '0, '0, 1'b1, 32'h200);
        cycle();
        all_differ();
        cycle();
        idle();
        check("clr_no_fatal", r2_fa, 1'b0);
        check("clr_block", r2_fb, 1'b1);
        run_recovery(1'b0, edges, beats, replays, d3, rpc);
        check("clr_replay_pc", rpc, 32'h200);

        // reset in the middle of a restore
        do_reset();
        set_all(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 32'h40);
        cycle();
        all_differ();
        cycle();
        idle();
        c = 0;
        while (r2_ra != 5'd10 && c < 40) begin cycle(); c++; end
        check("mid_reached_10", r2_ra, 5'd10);
        do_reset();
        check("mid_rst_block", r2_fb, 1'b0);
        check("mid_rst_addr", r2_ra, 0);
        cycle();
        all_differ();
        cycle();
        idle();
        run_recovery(1'b0, edges, beats, replays, d3, rpc);
        check("mid_rf3_cleared", d3, 0);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic w, r;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [PW-1:0] p;
            int sel, ln;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, DEPTH - 1));
            d = $urandom();
            p = $urandom() & 32'hFFFF_FFFC;
            set_all(w, a, d, r, p);
            sel = $urandom_range(0, 19);
            if (sel <= 1) begin
                ln = $urandom_range(0, 2);
                case ($urandom_range(0, 4))
                    0: lw[ln] = ~lw[ln];
                    1: la[ln] = la[ln] ^ AW'($urandom_range(1, DEPTH - 1));
                    2: ld[ln] = ld[ln] ^ (32'h1 << $urandom_range(0, 31));
                    3: lr[ln] = ~lr[ln];
                    default: lp[ln] = lp[ln] ^ (32'h4 << $urandom_range(0, 29));
                endcase
            end else if (sel == 2) begin
                ld[1] = ld[0] ^ 32'h1;
                ld[2] = ld[0] ^ 32'h2;
                lw[0] = 1'b1; lw[1] = 1'b1; lw[2] = 1'b1;
            end
            ready = ($urandom_range(0, 3) != 0);
            cycle();
            if ((n % 700 == 699) || (mst[0] == M_FATAL && mst[1] == M_FATAL)) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
